// File: rtl/data_mem_responder.sv
// Word-addressed data-memory slave for the core's load/store port: one request at a time,
// completed LATENCY cycles after acceptance with a single-cycle memReady pulse.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 6,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] Addressmem,
    input  logic [31:0] WriteDataMem,
    input  logic        memWrite,
    input  logic        memRead,
    output logic [31:0] ReadDataMem,
    output logic        memReady,
    output logic        memError,
    output logic        memStall,
    output logic [1:0]  fsm_state_o
);

    localparam int         DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic        rd_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        error_q;

    logic [31:0] mem [DEPTH];

    logic                  req;
    logic                  finish;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_data;
    logic                  acc_wr;
    logic                  acc_rd;
    logic                  acc_err;
    logic [ADDR_WIDTH-1:0] acc_idx;

    assign req = memRead | memWrite;

    // With LATENCY=1 the access completes on the accept edge, so it must use the live inputs.
    always_comb begin
        acc_addr = addr_q;
        acc_data = wdata_q;
        acc_wr   = wr_q;
        acc_rd   = rd_q;
        if (state_q == IDLE) begin
            acc_addr = Addressmem;
            acc_data = WriteDataMem;
            acc_wr   = memWrite;
            acc_rd   = memRead;
        end
    end

    assign acc_idx = acc_addr[ADDR_WIDTH+1:2];
    assign acc_err = (acc_addr[1:0] != 2'b00)
                   | ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0)
                   | (acc_wr & acc_rd);

    assign finish = ((state_q == IDLE) && req && (LATENCY == 1))
                  | ((state_q == BUSY) && (cnt_q == 4'd0));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= Addressmem;
                        wdata_q <= WriteDataMem;
                        wr_q    <= memWrite;
                        rd_q    <= memRead;
                        cnt_q   <= LAT_M1;
                        state_q <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (finish) begin
                ready_q <= 1'b1;
                error_q <= acc_err;
                if (acc_err) begin
                    rdata_q <= 32'd0;
                end else if (acc_rd) begin
                    rdata_q <= mem[acc_idx];
                end
            end
        end
    end

    // RAM is never cleared; a reset landing mid-access suppresses the pending write.
    always_ff @(posedge CLK) begin
        if (reset && finish && acc_wr && !acc_err) begin
            mem[acc_idx] <= acc_data;
        end
    end

    assign ReadDataMem = rdata_q;
    assign memReady    = ready_q;
    assign memError    = error_q;
    assign memStall    = req & ~ready_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, random write/read sweep and multi-cycle
// corner sequences (reset during response, held request, reset mid-access).
module tb_data_mem_responder;

  localparam int AW  = 6;
  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] rdata;
  logic        mem_ready;
  logic        mem_error;
  logic        mem_stall;
  logic [1:0]  fsm_state;

  int errors;
  int checks;

  logic [32:0] exp_q[$];
  logic [31:0] mdl[64];
  logic [31:0] cur_rd;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vec[12];

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .CLK          (clk),
    .reset        (rst_n),
    .Addressmem   (addr),
    .WriteDataMem (wdata),
    .memWrite     (mem_write),
    .memRead      (mem_read),
    .ReadDataMem  (rdata),
    .memReady     (mem_ready),
    .memError     (mem_error),
    .memStall     (mem_stall),
    .fsm_state_o  (fsm_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request at a negedge, hold until memReady, then drop it.
  task automatic do_access(input string name, input logic wr, input logic rd,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rdata, input logic exp_err);
    int          c;
    int          n_stall;
    logic [32:0] e;
    logic        seen;
    mem_write = wr;
    mem_read  = rd;
    addr      = a;
    wdata     = d;
    exp_q.push_back({exp_err, exp_rdata});
    #1;
    n_stall = mem_stall ? 1 : 0;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      if (mem_stall) n_stall++;
      if (mem_ready) seen = 1'b1;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_latency"}, 32'(c), 32'(LAT + 1));
      chk({name, "_stall_cycles"}, 32'(n_stall), 32'(LAT + 1));
      chk({name, "_rdata"}, rdata, e[31:0]);
      chk({name, "_err"}, 32'(mem_error), 32'(e[32]));
    end
    mem_write = 1'b0;
    mem_read  = 1'b0;
    @(negedge clk);
    chk({name, "_pulse"}, 32'(mem_ready), 32'd0);
  endtask

  task automatic count_ready(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (mem_ready) n++;
    end
  endtask

  initial begin
    int          n;
    int          c;
    int          idx;
    logic [31:0] d;

    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
    mem_write = 1'b0;
    mem_read  = 1'b0;

    vec[0]  = '{1'b1, 1'b0, 32'h10,  32'h12345678, 32'h0,        1'b0};
    vec[1]  = '{1'b0, 1'b1, 32'h10,  32'h0,        32'h12345678, 1'b0};
    vec[2]  = '{1'b1, 1'b0, 32'h13,  32'hAAAAAAAA, 32'h0,        1'b1};
    vec[3]  = '{1'b0, 1'b1, 32'h10,  32'h0,        32'h12345678, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 32'h100, 32'h0,        32'h0,        1'b1};
    vec[5]  = '{1'b1, 1'b1, 32'h0,   32'h77777777, 32'h0,        1'b1};
    vec[6]  = '{1'b1, 1'b0, 32'hFC,  32'hDEADBEEF, 32'h0,        1'b0};
    vec[7]  = '{1'b0, 1'b1, 32'hFC,  32'h0,        32'hDEADBEEF, 1'b0};
    vec[8]  = '{1'b0, 1'b1, 32'h2,   32'h0,        32'h0,        1'b1};
    vec[9]  = '{1'b1, 1'b0, 32'h0,   32'h55AA55AA, 32'h0,        1'b0};
    vec[10] = '{1'b0, 1'b1, 32'h0,   32'h0,        32'h55AA55AA, 1'b0};
    vec[11] = '{1'b0, 1'b1, 32'hFC,  32'h0,        32'hDEADBEEF, 1'b0};

    // power-on reset
    repeat (3) @(negedge clk);
    chk("por_rdata", rdata, 32'h0);
    chk("por_ready", 32'(mem_ready), 32'd0);
    chk("por_err", 32'(mem_error), 32'd0);
    chk("por_fsm", 32'(fsm_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("por_stall", 32'(mem_stall), 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_access($sformatf("vec%0d", i), vec[i].wr, vec[i].rd, vec[i].addr, vec[i].data,
                vec[i].exp_rdata, vec[i].exp_err);
    end
    cur_rd = 32'hDEADBEEF;

    // random sweep over words 32..47
    for (int i = 32; i < 48; i++) begin
      d = $urandom;
      mdl[i] = d;
      do_access($sformatf("rw%0d", i), 1'b1, 1'b0, 32'(i * 4), d, cur_rd, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      idx = $urandom_range(32, 47);
      cur_rd = mdl[idx];
      do_access($sformatf("rr%0d", idx), 1'b0, 1'b1, 32'(idx * 4), 32'h0, cur_rd, 1'b0);
    end

    // reset asserted while a read response is on the bus
    mem_read = 1'b1;
    addr     = 32'h10;
    c = 0;
    while (!mem_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("t1_ready_seen", 32'(mem_ready), 32'd1);
    chk("t1_pre_rdata", rdata, 32'h12345678);
    rst_n    = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("t1_rdata", rdata, 32'h0);
    chk("t1_ready", 32'(mem_ready), 32'd0);
    chk("t1_err", 32'(mem_error), 32'd0);
    chk("t1_fsm", 32'(fsm_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_stall", 32'(mem_stall), 32'd0);
    cur_rd = 32'h0;

    // store held across RESP is taken as a second access
    mem_write = 1'b1;
    addr      = 32'h4;
    wdata     = 32'h1;
    n = 0;
    for (int i = 0; i < 12 && n < 2; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        n++;
        if (n == 1) chk("t5_resp_stall", 32'(mem_stall), 32'd0);
      end
    end
    mem_write = 1'b0;
    chk("t5_hold_completions", 32'(n), 32'd2);
    count_ready(6, n);
    chk("t5_hold_tail", 32'(n), 32'd0);

    // store dropped on memReady completes once
    do_access("t5_drop", 1'b1, 1'b0, 32'h4, 32'h1, cur_rd, 1'b0);
    count_ready(6, n);
    chk("t5_drop_extra", 32'(n), 32'd0);
    do_access("t5_read", 1'b0, 1'b1, 32'h4, 32'h0, 32'h1, 1'b0);

    // reset during BUSY discards the pending store
    do_access("t6_prior", 1'b1, 1'b0, 32'h8, 32'h11112222, 32'h1, 1'b0);
    mem_write = 1'b1;
    addr      = 32'h8;
    wdata     = 32'hCAFEBABE;
    @(negedge clk);
    chk("t6_busy", 32'(fsm_state), 32'd1);
    rst_n     = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_ready(8, n);
    chk("t6_no_ready", 32'(n), 32'd0);
    do_access("t6_read", 1'b0, 1'b1, 32'h8, 32'h0, 32'h11112222, 1'b0);

    if (exp_q.size() != 0) chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
